dma_copy_controller: RTL and testbench
======================================

# dma_copy_controller

Word-granular memory-to-memory copy engine that acts as the second master on the shared system bus, alongside the CPU. It obtains bus tenure through the bus arbitrator's `dma_req`/`dma_grant` pair and performs read-then-write word transfers. It releases the bus after every burst so the CPU is never starved. Configuration comes from a simple start/parameter port driven by the CPU-side peripheral register block.

## Interface
- `BURST_LEN`, 4: words copied per bus tenure before yielding; must be ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse launching a copy; ignored while `busy`.
- `src_addr` in 32: source byte address, word-aligned.
- `dst_addr` in 32: destination byte address, word-aligned.
- `word_count` in 16: number of 32-bit words to copy.
- `busy` out 1: copy in progress.
- `done` out 1: one-cycle pulse when a copy completes.
- `dma_req` out 1: bus request to the arbitrator.
- `dma_grant` in 1: bus grant from the arbitrator (combinational from `dma_req`).
- `addr_bus` inout 32: shared address bus.
- `data_bus` inout 32: shared data bus.
- `wr_bus` inout 1: shared write strobe.
- `rd_bus` inout 1: shared read strobe.
- `data_mask_bus` inout 4: shared byte enables.
- `fc_bus` in 1: function-complete strobe from the addressed slave; read data is valid / write is accepted on the edge where it is high.

## Operation
- States: IDLE, REQUEST, READ, WRITE, YIELD.
- **IDLE**
  - On `start` with `word_count != 0`: latch `src`, `dst` and `remaining`, set `busy`, go to REQUEST.
  - On `start` with `word_count == 0`: pulse `done` next cycle and stay IDLE.
- **REQUEST**
  - `dma_req=1`.
  - When `dma_grant=1`: clear the burst counter and go to READ.
- **READ**
  - Drive `addr=src`, `rd=1`, `wr=0`, `mask=4'b1111`; `data_bus` is `z`.
  - On `fc_bus=1`: capture `data_bus` into the data register and go to WRITE.
- **WRITE**
  - Drive `addr=dst`, `data=data register`, `wr=1`, `rd=0`, `mask=4'b1111`.
  - On `fc_bus=1`: `src+=4`, `dst+=4`, `remaining-=1`, `burst+=1`. Then:
    - If `remaining` becomes 0: go to IDLE, clear `busy`, pulse `done`.
    - Otherwise, if `burst` reaches `BURST_LEN`: go to YIELD.
    - Otherwise: go to READ.
- **YIELD**
  - `dma_req=0` for exactly one cycle, then go to REQUEST.
  - This lets the arbitrator hand the bus to a pending CPU request.
- `dma_req` is high in REQUEST, READ and WRITE, and low in IDLE and YIELD.
- Bus outputs are driven only when `dma_grant=1` and the state is READ or WRITE. Otherwise every bus output is `z`.
- Grant loss in READ/WRITE is a protocol violation. The controller releases the bus immediately and returns to REQUEST, and the current word restarts at READ. Address and count registers are unchanged.
- Address arithmetic is modulo 2^32; wrap-around is silent. Bits [1:0] pass through unchanged.
- `remaining` is 16-bit, so the maximum copy is 65535 words.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `dma_req=0`, all bus outputs `z`, internal registers 0.
- `busy` rises on the edge after `start`. REQUEST is entered on that same edge.
- With immediate grant and zero-wait slaves (`fc_bus` high in the first cycle of each phase):
  - One REQUEST cycle, then 2 cycles per word.
  - One YIELD plus one REQUEST cycle are added per burst boundary.
  - Example: N=4, BURST_LEN=4 → `done` pulses 9 cycles after `start`.
- `done` and the `busy` fall are both registered and coincide with the edge that accepts the final write `fc_bus`.
- Reset asserted mid-copy aborts immediately. Outputs return to reset values asynchronously, with no `done` pulse.
- `start` coincident with the final `done` edge is ignored, because `busy` is still high at sampling.

## Structure
- Package `dma_pkg` holds:
  - the state enum `dma_state_t`;
  - `WORD_BYTES=4`;
  - `FULL_MASK=4'b1111`;
  - the width constants `ADDR_W=32` and `CNT_W=16`.
- One sub-module, `dma_bus_driver`: purely combinational tristate gating of `addr`/`data`/`wr`/`rd`/`mask` from an enable plus value inputs. The FSM, counters and data register stay in the top module.

## Test plan
- **Basic copy:** src=0x100, dst=0x200, count=3, BURST_LEN=4, zero-wait memory, grant tied to req → words at 0x200..0x208 equal 0x100..0x108; `done` 7 cycles after `start`; no YIELD.
- **Burst yield:** count=6, BURST_LEN=4, CPU requesting throughout → `dma_req` low for exactly one cycle after word 4; CPU granted; DMA resumes only after the CPU drops its request; all 6 words copied.
- **Slave wait states:** `fc_bus` delayed 3 cycles per phase → bus signals held stable until the `fc_bus` edge; data is correct; no extra increments.
- **Zero count and busy start:** `start` with count=0 → `done` next cycle, no bus activity. A second `start` while `busy` → ignored and the current copy is unaffected.
- **Wrap and reset:** src=0xFFFFFFFC, count=2 → second read at 0x00000000. Reset asserted mid-WRITE → bus goes `z` and `dma_req=0` immediately, no `done`.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy engine.
package dma_pkg;
    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 16;
    localparam int WORD_BYTES = 4;
    localparam logic [3:0] FULL_MASK = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        READ,
        WRITE,
        YIELD
    } dma_state_t;
endpackage

// File: rtl/dma_copy_controller_bus_driver.sv
// Tristate gating of the DMA's bus outputs; the bus floats unless the DMA owns it.
module dma_bus_driver
    import dma_pkg::*;
(
    input  logic              en,
    input  logic              data_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data,
    input  logic              wr,
    input  logic              rd,
    input  logic [3:0]        mask,
    inout  wire  [ADDR_W-1:0] addr_bus,
    inout  wire  [31:0]       data_bus,
    inout  wire               wr_bus,
    inout  wire               rd_bus,
    inout  wire  [3:0]        data_mask_bus
);
    assign addr_bus      = en ? addr : 'z;
    assign data_bus      = (en && data_en) ? data : 'z;
    assign wr_bus        = en ? wr : 1'bz;
    assign rd_bus        = en ? rd : 1'bz;
    assign data_mask_bus = en ? mask : 'z;
endmodule

// File: rtl/dma_copy_controller.sv
// Memory-to-memory word copy engine: second bus master, yields the bus after every burst.
module dma_copy_controller
    import dma_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              dma_req,
    input  logic              dma_grant,
    inout  wire  [ADDR_W-1:0] addr_bus,
    inout  wire  [31:0]       data_bus,
    inout  wire               wr_bus,
    inout  wire               rd_bus,
    inout  wire  [3:0]        data_mask_bus,
    input  logic              fc_bus
);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);

    dma_state_t        state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  burst;
    logic [31:0]       data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            dma_req   <= 1'b0;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            burst     <= '0;
            data_reg  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            src       <= src_addr;
                            dst       <= dst_addr;
                            remaining <= word_count;
                            busy      <= 1'b1;
                            dma_req   <= 1'b1;
                            state     <= REQUEST;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                REQUEST: begin
                    if (dma_grant) begin
                        burst <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    // Losing the grant mid-word restarts that word from its read.
                    if (!dma_grant) begin
                        state <= REQUEST;
                    end else if (fc_bus) begin
                        data_reg <= data_bus;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (!dma_grant) begin
                        state <= REQUEST;
                    end else if (fc_bus) begin
                        src       <= src + ADDR_STEP;
                        dst       <= dst + ADDR_STEP;
                        remaining <= remaining - 1'b1;
                        burst     <= burst + 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            dma_req <= 1'b0;
                        end else if (burst == BURST_LAST) begin
                            state   <= YIELD;
                            dma_req <= 1'b0;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                YIELD: begin
                    state   <= REQUEST;
                    dma_req <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    dma_req <= 1'b0;
                end
            endcase
        end
    end

    logic bus_en;
    logic in_write;

    assign in_write = (state == WRITE);
    assign bus_en   = dma_grant && ((state == READ) || in_write);

    dma_bus_driver u_bus_driver (
        .en            (bus_en),
        .data_en       (in_write),
        .addr          (in_write ? dst : src),
        .data          (data_reg),
        .wr            (in_write),
        .rd            (state == READ),
        .mask          (FULL_MASK),
        .addr_bus      (addr_bus),
        .data_bus      (data_bus),
        .wr_bus        (wr_bus),
        .rd_bus        (rd_bus),
        .data_mask_bus (data_mask_bus)
    );
endmodule

// File: tb/tb_dma_copy_controller.sv
// Self-checking bench: zero/wait-state memory, CPU arbiter model and a write scoreboard.
module tb_dma_copy_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        dma_req;
    logic        dma_grant;
    logic        fc_bus;
    tri0  [31:0] addr_bus;
    tri0  [31:0] data_bus;
    tri0         wr_bus;
    tri0         rd_bus;
    tri0  [3:0]  data_mask_bus;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dma_copy_controller #(.BURST_LEN(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .word_count    (word_count),
        .busy          (busy),
        .done          (done),
        .dma_req       (dma_req),
        .dma_grant     (dma_grant),
        .addr_bus      (addr_bus),
        .data_bus      (data_bus),
        .wr_bus        (wr_bus),
        .rd_bus        (rd_bus),
        .data_mask_bus (data_mask_bus),
        .fc_bus        (fc_bus)
    );

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- slave memory model ----------------
    int          wait_states = 0;
    int          phase_cnt   = 0;
    int          unstable    = 0;
    int          bus_act     = 0;
    int          wr_acc      = 0;
    logic [31:0] phase_addr  = '0;

    assign data_bus = (rd_bus && !wr_bus) ? pat(addr_bus) : 'z;
    assign fc_bus   = (rd_bus || wr_bus) && (phase_cnt >= wait_states);

    always @(posedge clk) begin
        if (rd_bus || wr_bus) begin
            bus_act++;
            if (phase_cnt == 0) phase_addr <= addr_bus;
            else if (addr_bus !== phase_addr) unstable++;
            phase_cnt <= fc_bus ? 0 : phase_cnt + 1;
        end else begin
            phase_cnt <= 0;
        end
    end

    // ---------------- CPU / arbiter model ----------------
    logic cpu_req = 1'b0;
    logic cpu_own;

    assign dma_grant = dma_req && !cpu_own;

    always @(posedge clk or posedge rst) begin
        if (rst) cpu_own <= 1'b0;
        else     cpu_own <= cpu_req && (cpu_own || !dma_req);
    end

    // ---------------- write scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    always @(posedge clk) begin
        if (!rst && wr_bus && fc_bus) begin
            wr_acc++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got write at %h, required none", addr_bus);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", addr_bus, e.addr);
                check("wr_data", data_bus, e.data);
                check("wr_mask", {28'd0, data_mask_bus}, 32'hF);
            end
        end
    end

    task automatic push_exp(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr = d + 32'(4 * i);
            e.data = pat(s + 32'(4 * i));
            exp_q.push_back(e);
        end
    endtask

    // Pulse start; returns with time #1 after the sampling edge.
    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        src_addr   = s;
        dst_addr   = d;
        word_count = n;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int offset, output int cycles);
        cycles = offset;
        while (!done && cycles < 3000) begin
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] n;
        int          w;
        int          lat;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int cyc;
        int act0;
        int req_low;
        int cpu_cyc;
        int conflict;
        int wr_at_yield;

        vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd3, 0, 7};
        vecs[1] = '{32'h0000_1000, 32'h0000_2000, 16'd4, 0, 9};
        vecs[2] = '{32'h0000_3000, 32'h0000_4000, 16'd5, 0, 13};
        vecs[3] = '{32'h0000_5000, 32'h0000_6000, 16'd8, 0, 19};
        vecs[4] = '{32'h0000_7000, 32'h0000_8000, 16'd2, 3, 17};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0000_9000, 16'd2, 0, 5};
        vecs[6] = '{32'h0000_A000, 32'h0000_B000, 16'd9, 1, 41};
        vecs[7] = '{32'h0000_0123, 32'h0000_0456, 16'd0, 0, 0};

        rst        = 1'b1;
        start      = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        word_count = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_req", {31'd0, dma_req}, 32'd0);
        check("reset_rd", {31'd0, rd_bus}, 32'd0);
        check("reset_wr", {31'd0, wr_bus}, 32'd0);
        check("reset_addr", addr_bus, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Table-driven copies, each with its own latency expectation.
        for (int v = 0; v < 8; v++) begin
            wait_states = vecs[v].w;
            push_exp(vecs[v].src, vecs[v].dst, int'(vecs[v].n));
            act0 = bus_act;
            launch(vecs[v].src, vecs[v].dst, vecs[v].n);
            if (vecs[v].n != 0) check($sformatf("v%0d_busy_rise", v), {31'd0, busy}, 32'd1);
            wait_done(0, cyc);
            check($sformatf("v%0d_latency", v), cyc, vecs[v].lat);
            check($sformatf("v%0d_busy_fall", v), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_pending", v), exp_q.size(), 32'd0);
            if (vecs[v].n == 0) check("zero_bus_act", bus_act - act0, 32'd0);
            @(posedge clk);
            #1 check($sformatf("v%0d_done_pulse", v), {31'd0, done}, 32'd0);
            $display("copy v%0d src=%h dst=%h n=%0d wait=%0d latency=%0d", v,
                     vecs[v].src, vecs[v].dst, vecs[v].n, vecs[v].w, cyc);
        end
        check("addr_stable", unstable, 32'd0);

        // Burst yield with the CPU competing for the bus.
        wait_states = 0;
        push_exp(32'h0001_0000, 32'h0002_0000, 6);
        launch(32'h0001_0000, 32'h0002_0000, 16'd6);
        cyc = 0; req_low = 0; cpu_cyc = 0; conflict = 0; wr_at_yield = -1;
        while (!done && cyc < 3000) begin
            if (cyc == 3) cpu_req = 1'b1;
            @(posedge clk);
            #1 cyc++;
            if (busy && !dma_req) begin
                req_low++;
                if (wr_at_yield < 0) wr_at_yield = wr_acc;
            end
            if (cpu_own) begin
                cpu_cyc++;
                if (rd_bus || wr_bus) conflict++;
                if (cpu_cyc == 4) cpu_req = 1'b0;
            end
        end
        check("yield_req_low", req_low, 32'd1);
        check("yield_cpu_cycles", cpu_cyc, 32'd4);
        check("yield_conflict", conflict, 32'd0);
        check("yield_after_words", wr_at_yield - (wr_acc - 6), 32'd4);
        check("yield_latency", cyc, 32'd19);
        check("yield_pending", exp_q.size(), 32'd0);
        $display("copy burst_yield n=6 latency=%0d cpu_cycles=%0d", cyc, cpu_cyc);

        // A start while busy is ignored and the running copy is unaffected.
        push_exp(32'h0000_0300, 32'h0000_0400, 4);
        launch(32'h0000_0300, 32'h0000_0400, 16'd4);
        repeat (2) begin @(posedge clk); #1; end
        src_addr   = 32'h0000_0900;
        word_count = 16'd2;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(3, cyc);
        check("busy_start_latency", cyc, 32'd9);
        check("busy_start_pending", exp_q.size(), 32'd0);
        @(posedge clk);
        #1 check("busy_start_idle", {31'd0, busy}, 32'd0);
        $display("copy busy_start latency=%0d", cyc);

        // Start held through the final done edge is ignored.
        push_exp(32'h0000_0500, 32'h0000_0600, 1);
        launch(32'h0000_0500, 32'h0000_0600, 16'd1);
        @(posedge clk);
        #1 start = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("done_edge_done", {31'd0, done}, 32'd1);
        start = 1'b0;
        @(posedge clk);
        #1 check("done_edge_busy", {31'd0, busy}, 32'd0);
        check("done_edge_pending", exp_q.size(), 32'd0);
        $display("copy done_edge_start busy=%0d", busy);

        // Asynchronous reset in the middle of a write.
        push_exp(32'h0000_0700, 32'h0000_0800, 4);
        launch(32'h0000_0700, 32'h0000_0800, 16'd4);
        cyc = 0;
        while (!wr_bus && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("rst_saw_write", {31'd0, wr_bus}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_req", {31'd0, dma_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr", {31'd0, wr_bus}, 32'd0);
        check("rst_addr", addr_bus, 32'd0);
        check("rst_data", data_bus, 32'd0);
        exp_q.delete();
        act0 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 if (done || busy || rd_bus || wr_bus) act0++;
        end
        check("rst_no_done", act0, 32'd0);
        $display("copy reset_abort activity_after=%0d", act0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
